arith_mac_pipe: RTL and testbench
=================================

Name: arith_mac_pipe

Overview:
- Registered, handshaked arithmetic stage consuming operand pairs (var1, var2 style, 8-bit) from the stimulus/sequencer side.
- Produces per-pair sum and product plus a running saturating accumulation of products.
- Replaces free-running combinational sum/product evaluation with a clocked 2-stage pipeline.
- Results feed downstream monitors/loggers via a valid/ready interface.

Parameters:
- DATA_W, 8, operand width.
- ACC_W, 24, accumulator width; must be >= 2*DATA_W.
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept the pair.
- in_a  in  DATA_W  operand A, unsigned.
- in_b  in  DATA_W  operand B, unsigned.
- acc_clr  in  1  synchronous accumulator clear request.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  DATA_W+1  a+b.
- out_prod  out  2*DATA_W  a*b.
- out_acc  out  ACC_W  accumulator value including this result.
- out_sat  out  1  accumulator saturated (sticky).
- op_count  out  CNT_W  number of accepted pairs, wraps.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids 0, all data registers 0, accumulator 0, sat 0, op_count 0. All outputs read 0 during reset, except in_ready.
- in_ready while rst_n is low: 0.
- Stall condition: stall = out_valid & ~out_ready.
- in_ready = ~stall. This is combinational from out_ready (intentional, documented).
- Stalled pipeline: both stages hold all registers unchanged.
- Accept: in_valid & in_ready on a rising edge.
  - Stage 1 captures a and b; s1_valid <= 1.
  - op_count increments, wrapping from 2^CNT_W-1 to 0.
  - Without an accept and without a stall, s1_valid <= 0.
- Stage 2: when ~stall, it loads from stage 1.
  - sum = a+b, full DATA_W+1 bits, no overflow.
  - prod = a*b, full 2*DATA_W bits.
  - out_valid <= s1_valid.
- Latency: a pair accepted at edge N appears with out_valid=1 after edge N+1 (2 registers). Throughput is 1 pair/cycle when out_ready stays high.
- Accumulator update: only when a valid stage-1 entry moves into stage 2 (s1_valid & ~stall).
  - acc_next = acc + prod.
  - If the true sum is >= 2^ACC_W, acc_next = 2^ACC_W-1 and sat <= 1.
  - At saturation, acc holds and further adds are no-ops.
- out_acc and out_sat are registered alongside the stage-2 result and reflect the state after including this result.
- acc_clr, sampled every edge and ignoring the stall:
  - Alone: acc <= 0, sat <= 0.
  - Coincident with an update: clear first, then add, so acc = prod and sat = 0 (prod always fits).
  - During a stall: the internal acc clears, but the held out_acc is not modified until the next update.
- Bubble handling: out_valid=0 with data registers unchanged; downstream ignores the data.
- Output rule: out_valid never drops while out_ready is low; out data is stable while stalled.
- Reset mid-operation discards in-flight pairs; there is no partial output afterwards.
- No combinational path from in_a/in_b to any output.

Test Plan:
- Reset, then accept (10,99) with out_ready=1 -> two edges later out_valid=1, sum=109, prod=990, acc=990, op_count=1.
- Back-to-back (10,33), (132,33), (4,33) after a clr -> sums 43, 165, 37; prods 330, 4356, 132; acc 330, 4686, 4818 on consecutive cycles.
- Hold out_ready=0 for 3 cycles with 2 pairs in flight -> in_ready=0, out data frozen (first result), no pair lost; after release both results appear in order.
- ACC_W=16, two pairs (255,255) -> sum=510, prod=65025, acc 65025 then 65535 with sat=1; next (1,1) keeps acc=65535. Asserting acc_clr with (2,3) -> acc=6, sat=0.
- acc_clr asserted on the same edge as (10,99) moves into stage 2 with prior acc=500 -> out_acc=990.
- Assert rst_n low mid-stream with 2 pairs in flight -> outputs 0 immediately (asynchronously); no result emitted after release; op_count restarts at 0. 256 accepts with CNT_W=8 -> op_count wraps to 0.

Source files
------------

// File: rtl/arith_mac_pipe.sv
// rtl/arith_mac_pipe.sv - two-stage handshaked add/multiply stage with saturating product accumulator
module arith_mac_pipe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W:0]     out_sum,
  output logic [2*DATA_W-1:0] out_prod,
  output logic [ACC_W-1:0]    out_acc,
  output logic                out_sat,
  output logic [CNT_W-1:0]    op_count
);

  localparam int PAD_W = ACC_W + 1 - 2 * DATA_W;

  logic                r_s1_valid;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_out_valid;
  logic [DATA_W:0]     r_sum;
  logic [2*DATA_W-1:0] r_prod;
  logic [ACC_W-1:0]    r_out_acc;
  logic                r_out_sat;
  logic [ACC_W-1:0]    r_acc;
  logic                r_sat;
  logic [CNT_W-1:0]    r_count;

  logic                w_stall;
  logic                w_accept;
  logic                w_update;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_acc_base;
  logic                w_sat_base;
  logic [ACC_W:0]      w_acc_add;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_sat_next;

  // A held result blocks both stages; in_ready follows out_ready combinationally.
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = rst_n & ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_update = r_s1_valid & ~w_stall;

  // Arithmetic works only on registered operands, so inputs never reach outputs combinationally.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};

  // Clear applies before the add, so a clear coincident with an update leaves just this product.
  always_comb begin
    w_acc_base = acc_clr ? '0 : r_acc;
    w_sat_base = acc_clr ? 1'b0 : r_sat;
    w_acc_add  = {1'b0, w_acc_base} + {{PAD_W{1'b0}}, w_prod};
    w_acc_next = w_acc_base;
    w_sat_next = w_sat_base;
    if (w_update && !w_sat_base) begin
      if (w_acc_add[ACC_W]) begin
        w_acc_next = '1;
        w_sat_next = 1'b1;
      end else begin
        w_acc_next = w_acc_add[ACC_W-1:0];
      end
    end
  end

  // Stage 1: capture operands on accept, count accepts, insert a bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_count    <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Stage 2: load results from stage 1; bubbles leave the data registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_prod      <= '0;
      r_out_acc   <= '0;
      r_out_sat   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum     <= w_sum;
        r_prod    <= w_prod;
        r_out_acc <= w_acc_next;
        r_out_sat <= w_sat_next;
      end
    end
  end

  // Internal accumulator sees acc_clr on every edge, even while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_sat <= w_sat_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_prod  = r_prod;
  assign out_acc   = r_out_acc;
  assign out_sat   = r_out_sat;
  assign op_count  = r_count;

endmodule

// File: tb/tb_arith_mac_pipe.sv
// tb/tb_arith_mac_pipe.sv - self-checking bench for arith_mac_pipe (24-bit and 16-bit accumulators)
module tb_arith_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, acc_clr, out_ready;
  logic [7:0] in_a, in_b;

  logic        in_ready, out_valid, out_sat;
  logic [8:0]  out_sum;
  logic [15:0] out_prod;
  logic [23:0] out_acc;
  logic [7:0]  op_count;

  logic        in_ready16, out_valid16, out_sat16;
  logic [8:0]  out_sum16;
  logic [15:0] out_prod16, out_acc16;
  logic [7:0]  op_count16;

  arith_mac_pipe #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_prod(out_prod),
    .out_acc(out_acc), .out_sat(out_sat), .op_count(op_count));

  arith_mac_pipe #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .out_valid(out_valid16),
    .out_ready(out_ready), .out_sum(out_sum16), .out_prod(out_prod16),
    .out_acc(out_acc16), .out_sat(out_sat16), .op_count(op_count16));

  int checks = 0;
  int errors = 0;

  // Reference: running saturating sum of products since the last clear, per accumulator width.
  longint      m_acc [2];
  bit          m_sat [2];
  int unsigned m_cnt;

  logic [67:0] w_obs;
  assign w_obs = {out_valid, out_sum, out_prod, out_acc, out_sat, out_acc16, out_sat16};

  function automatic void model_clr();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_sat[k] = 1'b0;
    end
  endfunction

  function automatic void model_add(input int p);
    longint lim;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? (longint'(1) << 24) : (longint'(1) << 16);
      if (!m_sat[k]) begin
        if (m_acc[k] + p >= lim) begin
          m_acc[k] = lim - 1;
          m_sat[k] = 1'b1;
        end else begin
          m_acc[k] = m_acc[k] + p;
        end
      end
    end
  endfunction

  function automatic logic [67:0] pack(input logic v, input int s, input int p);
    return {v, 9'(s), 16'(p), 24'(m_acc[0]), m_sat[0], 16'(m_acc[1]), m_sat[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    in_a = 8'd0; in_b = 8'd0; m_cnt = 0;
    model_clr();
    tick(); tick();
    checks++;
    if (w_obs !== 68'd0 || op_count !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got %h cnt %0d, expected 0", w_obs, op_count);
    end
    checks++;
    if (in_ready !== 1'b0 || in_ready16 !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b, expected 0", in_ready, in_ready16);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    in_a = 8'd10; in_b = 8'd99; in_valid = 1'b1;
    tick();
    m_cnt++;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 8'd1) begin
      errors++; $display("FAIL basic_latency: got valid %b cnt %0d, expected 0/1", out_valid, op_count);
    end
    tick();
    model_add(990);
    checks++;
    if (w_obs !== pack(1'b1, 109, 990) || op_count !== 8'd1) begin
      errors++; $display("FAIL basic_result: got %h, expected %h", w_obs, pack(1'b1, 109, 990));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_bubble: got valid %b, expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int a [3] = '{10, 132, 4};
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_clr();
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin
        in_a = 8'(a[i]); in_b = 8'd33;
      end
      tick();
      if (i < 3) m_cnt++;
      if (i > 0) begin
        model_add(a[i-1] * 33);
        checks++;
        if (w_obs !== pack(1'b1, a[i-1] + 33, a[i-1] * 33)) begin
          errors++; $display("FAIL b2b_%0d: got %h, expected %h", i - 1, w_obs, pack(1'b1, a[i-1] + 33, a[i-1] * 33));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_acc !== 24'd4818) begin
      errors++; $display("FAIL b2b_acc: got %0d, expected 4818", out_acc);
    end
  endtask

  task automatic test_stall();
    logic [67:0] exp1;
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9;
    tick(); m_cnt++;
    in_a = 8'd20; in_b = 8'd30;
    tick(); m_cnt++;
    model_add(63);
    exp1 = pack(1'b1, 16, 63);
    out_ready = 1'b0; in_a = 8'd5; in_b = 8'd6;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_obs !== exp1 || in_ready !== 1'b0 || op_count !== 8'(m_cnt)) begin
        errors++; $display("FAIL stall_hold_%0d: got %h rdy %b cnt %0d, expected %h rdy 0 cnt %0d",
                           i, w_obs, in_ready, op_count, exp1, m_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    tick(); m_cnt++;
    in_valid = 1'b0;
    model_add(600);
    checks++;
    if (w_obs !== pack(1'b1, 50, 600)) begin
      errors++; $display("FAIL stall_second: got %h, expected %h", w_obs, pack(1'b1, 50, 600));
    end
    tick();
    model_add(30);
    checks++;
    if (w_obs !== pack(1'b1, 11, 30) || op_count !== 8'(m_cnt)) begin
      errors++; $display("FAIL stall_third: got %h, expected %h", w_obs, pack(1'b1, 11, 30));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got valid %b, expected 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    int a [4] = '{255, 255, 1, 2};
    int b [4] = '{255, 255, 1, 3};
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_clr();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      if (i < 4) begin
        in_a = 8'(a[i]); in_b = 8'(b[i]);
      end
      acc_clr = (i == 4);
      tick();
      acc_clr = 1'b0;
      if (i < 4) m_cnt++;
      if (i > 0) begin
        if (i == 4) model_clr();
        model_add(a[i-1] * b[i-1]);
        checks++;
        if (w_obs !== pack(1'b1, a[i-1] + b[i-1], a[i-1] * b[i-1])) begin
          errors++; $display("FAIL sat_%0d: got %h, expected %h", i - 1, w_obs, pack(1'b1, a[i-1] + b[i-1], a[i-1] * b[i-1]));
        end
      end
      if (i == 2) begin
        checks++;
        if (out_acc16 !== 16'hFFFF || out_sat16 !== 1'b1) begin
          errors++; $display("FAIL sat_limit16: got %0d sat %b, expected 65535 sat 1", out_acc16, out_sat16);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clr_coincident();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_clr();
    in_valid = 1'b1; in_a = 8'd20; in_b = 8'd25;
    tick(); m_cnt++;
    in_a = 8'd10; in_b = 8'd99;
    tick(); m_cnt++;
    in_valid = 1'b0;
    model_add(500);
    checks++;
    if (out_acc !== 24'd500) begin
      errors++; $display("FAIL clr_prior: got %0d, expected 500", out_acc);
    end
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_clr();
    model_add(990);
    checks++;
    if (w_obs !== pack(1'b1, 109, 990) || out_acc !== 24'd990) begin
      errors++; $display("FAIL clr_coincident: got %h, expected %h", w_obs, pack(1'b1, 109, 990));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4;
    tick();
    in_a = 8'd5; in_b = 8'd6;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== 68'd0 || op_count !== 8'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_async: got %h cnt %0d rdy %b, expected 0", w_obs, op_count, in_ready);
    end
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_clr();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || op_count !== 8'd0) begin
        errors++; $display("FAIL reset_discard_%0d: got valid %b cnt %0d, expected 0/0", i, out_valid, op_count);
      end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
      m_cnt = (m_cnt + 1) % 256;
      checks++;
      if (op_count !== 8'(m_cnt) || (i == 256 && op_count !== 8'd0)) begin
        errors++; $display("FAIL wrap_%0d: got %0d, expected %0d", i, op_count, m_cnt);
      end
    end
    in_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [67:0] q [$];
    logic [67:0] snap;
    logic        held, exp_rdy;
    int          p;
    acc_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_clr();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 10) < 7;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom % 10) < 7;
      #1;
      exp_rdy = !(out_valid && !out_ready);
      checks++;
      if (in_ready !== exp_rdy || in_ready16 !== exp_rdy) begin
        errors++; $display("FAIL rand_ready_%0d: got %b/%b, expected %b", c, in_ready, in_ready16, exp_rdy);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra_%0d: got %h, expected no result", c, w_obs);
        end else if (w_obs !== q[0]) begin
          errors++; $display("FAIL rand_result_%0d: got %h, expected %h", c, w_obs, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        p = int'(in_a) * int'(in_b);
        model_add(p);
        q.push_back(pack(1'b1, int'(in_a) + int'(in_b), p));
        m_cnt = (m_cnt + 1) % 256;
      end
      held = out_valid && !out_ready;
      snap = w_obs;
      @(posedge clk);
      #1;
      if (held) begin
        checks++;
        if (w_obs !== snap) begin
          errors++; $display("FAIL rand_stable_%0d: got %h, expected %h", c, w_obs, snap);
        end
      end
      checks++;
      if (op_count !== 8'(m_cnt)) begin
        errors++; $display("FAIL rand_count_%0d: got %0d, expected %0d", c, op_count, m_cnt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || w_obs !== q[0]) begin
          errors++; $display("FAIL rand_drain_%0d: got %h, expected %h", c, w_obs, (q.size() != 0) ? q[0] : 68'd0);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rand_lost: got %0d results missing, expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_clr_coincident();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
